// File: rtl/mem_access_unit.sv
// Load/store sequencer between a core request port and a word-wide big-endian data memory.
// Latency: error 1, load 2, word store 2, sub-word store 3 cycles from the accepting edge to done.
// Backpressure: a single access is in flight; req is ignored while busy and nothing is queued.
module mem_access_unit #(
  parameter int unsigned ADDR_LIMIT = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        mem_rw,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_we;
  logic        r_sext;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_word;
  logic [31:0] r_rdata;

  logic        w_misalign;
  logic [32:0] w_last_byte;
  logic        w_out_of_range;
  logic        w_req_err;
  logic        w_accept;
  logic [31:0] w_word_addr;
  logic [31:0] w_store_word;
  logic [31:0] w_load_val;

  // Pick the addressed lane out of a big-endian word and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  off,
                                               input logic [1:0]  sz,
                                               input logic        sx);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (off)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (sz)
      SZ_BYTE: res = {{24{sx & b[7]}}, b};
      SZ_HALF: res = {{16{sx & h[15]}}, h};
      default: res = word;
    endcase
    return res;
  endfunction

  // Replace only the addressed lane of the captured word with the store data.
  function automatic logic [31:0] merge_lane(input logic [31:0] word,
                                             input logic [1:0]  off,
                                             input logic [1:0]  sz,
                                             input logic [31:0] wd);
    logic [31:0] res;
    res = word;
    case (sz)
      SZ_BYTE: begin
        case (off)
          2'd0:    res[31:24] = wd[7:0];
          2'd1:    res[23:16] = wd[7:0];
          2'd2:    res[15:8]  = wd[7:0];
          default: res[7:0]   = wd[7:0];
        endcase
      end
      SZ_HALF: begin
        if (off[1]) res[15:0]  = wd[15:0];
        else        res[31:16] = wd[15:0];
      end
      default: res = wd;
    endcase
    return res;
  endfunction

  // Reject checks on the live request; the range check uses 33 bits so addresses near 2^32 cannot wrap.
  assign w_misalign     = (size == SZ_ILL) ||
                          ((size == SZ_HALF) && addr[0]) ||
                          ((size == SZ_WORD) && (addr[1:0] != 2'b00));
  assign w_last_byte    = {1'b0, addr[31:2], 2'b00} + 33'd3;
  assign w_out_of_range = (w_last_byte >= 33'(ADDR_LIMIT));
  assign w_req_err      = w_misalign || w_out_of_range;
  assign w_accept       = (r_state == ST_IDLE) && req;

  assign w_word_addr  = {r_addr[31:2], 2'b00};
  assign w_store_word = merge_lane(r_word, r_addr[1:0], r_size, r_wdata);
  assign w_load_val   = load_extract(mem_rdata, r_addr[1:0], r_size, r_sext);

  assign rdata = r_rdata;

  // State register; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state routing and all memory/handshake outputs decoded from the current state.
  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    err         = 1'b0;
    mem_en      = 1'b0;
    mem_rw      = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    case (r_state)
      ST_IDLE: begin
        if (req) begin
          if (w_req_err)            w_state_nxt = ST_DONE;
          else if (!we)             w_state_nxt = ST_RD;
          else if (size == SZ_WORD) w_state_nxt = ST_WR;
          else                      w_state_nxt = ST_RD;
        end
      end
      ST_RD: begin
        busy        = 1'b1;
        mem_en      = 1'b1;
        mem_addr    = w_word_addr;
        w_state_nxt = r_we ? ST_WR : ST_DONE;
      end
      ST_WR: begin
        busy        = 1'b1;
        mem_rw      = 1'b1;
        mem_addr    = w_word_addr;
        mem_wdata   = w_store_word;
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        err         = r_err;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Request capture in IDLE, read-word capture in RD, and load result update on the RD->DONE edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= 32'd0;
      r_size  <= 2'd0;
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_wdata <= 32'd0;
      r_err   <= 1'b0;
      r_word  <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      if (w_accept) begin
        r_addr  <= addr;
        r_size  <= size;
        r_we    <= we;
        r_sext  <= sign_ext;
        r_wdata <= wdata;
        r_err   <= w_req_err;
      end
      if (r_state == ST_RD) begin
        r_word <= mem_rdata;
        if (!r_we) r_rdata <= w_load_val;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int LIMIT = 256;

  logic        clk;
  logic        rst;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        mem_rw;
  logic        mem_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic        mem_init;
  logic [31:0] mem     [64];
  logic [31:0] ref_mem [64];
  logic [31:0] model_rdata;

  int total;
  int bad;

  mem_access_unit #(.ADDR_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .mem_rw    (mem_rw),
    .mem_en    (mem_en),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h01030507) ^ 32'h5A5AA5A5;
  endfunction

  // Attached data memory: combinational read, write on the rising edge.
  assign mem_rdata = mem[mem_addr[7:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
    end else if (mem_rw) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic e_busy, input logic e_done, input logic e_err,
                               input logic e_en, input logic e_rw, input logic [31:0] e_maddr,
                               input logic [31:0] e_mwd, input logic [31:0] e_rdata);
    chk1 ("busy",      busy,      e_busy);
    chk1 ("done",      done,      e_done);
    chk1 ("err",       err,       e_err);
    chk1 ("mem_en",    mem_en,    e_en);
    chk1 ("mem_rw",    mem_rw,    e_rw);
    chk32("mem_addr",  mem_addr,  e_maddr);
    chk32("mem_wdata", mem_wdata, e_mwd);
    chk32("rdata",     rdata,     e_rdata);
  endtask

  // Reference rules, expressed on a 4-byte big-endian view of each memory word.
  function automatic bit model_err(input logic [1:0] sz, input logic [31:0] a);
    logic [63:0] base;
    base = {32'd0, a[31:2], 2'b00};
    return (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
           (base + 64'd3 >= 64'(LIMIT));
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] w, input int off,
                                             input logic [1:0] sz, input logic sx);
    logic [7:0]  b [4];
    logic [31:0] v;
    for (int k = 0; k < 4; k++) b[k] = w[8*(3-k) +: 8];
    case (sz)
      2'd0: begin
        v = {24'd0, b[off]};
        if (sx && b[off][7]) v = v | 32'hFFFFFF00;
      end
      2'd1: begin
        v = {16'd0, b[off], b[off+1]};
        if (sx && b[off][7]) v = v | 32'hFFFF0000;
      end
      default: v = w;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] w, input int off,
                                              input logic [1:0] sz, input logic [31:0] wd);
    logic [7:0] b [4];
    for (int k = 0; k < 4; k++) b[k] = w[8*(3-k) +: 8];
    case (sz)
      2'd0: b[off] = wd[7:0];
      2'd1: begin
        b[off]   = wd[15:8];
        b[off+1] = wd[7:0];
      end
      default: return wd;
    endcase
    return {b[0], b[1], b[2], b[3]};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      req = 1'b0;
      @(negedge clk);
      check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, model_rdata);
    end
  endtask

  // One access: drive it in the next cycle, check every cycle until done, then retire it into the model.
  task automatic access(input logic i_we, input logic [1:0] i_size, input logic i_sx,
                        input logic [31:0] i_addr, input logic [31:0] i_wdata, input bit hold,
                        output int done_at, output int n_en, output int n_rw, output bit saw_err);
    int          lat;
    int          idx;
    int          off;
    bit          e_err;
    bit          e_rd;
    bit          e_wr;
    logic [31:0] old_w;
    logic [31:0] new_w;
    logic [31:0] new_rd;
    logic [31:0] waddr;
    logic        x_done;
    logic        x_en;
    logic        x_rw;
    e_err  = model_err(i_size, i_addr);
    idx    = int'(i_addr[7:2]);
    off    = int'(i_addr[1:0]);
    waddr  = i_addr & ~32'h3;
    old_w  = e_err ? 32'd0 : ref_mem[idx];
    if (e_err)                lat = 1;
    else if (!i_we)           lat = 2;
    else if (i_size == 2'd2)  lat = 2;
    else                      lat = 3;
    e_rd   = !e_err && !(i_we && i_size == 2'd2);
    e_wr   = !e_err && i_we;
    new_w  = e_wr ? model_store(old_w, off, i_size, i_wdata) : old_w;
    new_rd = (!e_err && !i_we) ? model_load(old_w, off, i_size, i_sx) : model_rdata;

    @(posedge clk); #1;
    req = 1'b1; we = i_we; size = i_size; sign_ext = i_sx; addr = i_addr; wdata = i_wdata;
    @(negedge clk);
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, model_rdata);
    @(posedge clk); #1;
    if (hold) begin
      req = 1'b1; we = ~i_we; size = 2'($urandom); sign_ext = ~i_sx;
      addr = $urandom_range(0, 255); wdata = $urandom;
    end else begin
      req = 1'b0;
    end
    done_at = -1; n_en = 0; n_rw = 0; saw_err = 1'b0;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (done === 1'b1 && err === 1'b1) saw_err = 1'b1;
      if (mem_en === 1'b1) n_en++;
      if (mem_rw === 1'b1) n_rw++;
      x_done = (k == lat);
      x_en   = e_rd && (k == 1);
      x_rw   = e_wr && (k == lat - 1);
      check_outputs(1'b1, x_done, x_done && e_err, x_en, x_rw,
                    (x_en || x_rw) ? waddr : 32'd0, x_rw ? new_w : 32'd0,
                    x_done ? new_rd : model_rdata);
      if (k < lat) begin
        @(posedge clk); #1;
      end
    end
    if (e_wr) ref_mem[idx] = new_w;
    model_rdata = new_rd;
    if (!e_err) chk32("mem_word", mem[idx], ref_mem[idx]);
  endtask

  initial begin
    int          d_at;
    int          ne;
    int          nr;
    bit          se;
    logic        r_we_v;
    logic        r_sx_v;
    logic [1:0]  r_sz_v;
    logic [31:0] r_ad_v;
    logic [31:0] r_wd_v;
    bit          r_hold;

    total = 0; bad = 0;
    req = 1'b0; we = 1'b0; size = 2'd0; sign_ext = 1'b0; addr = 32'd0; wdata = 32'd0;
    model_rdata = 32'd0;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; mem_init = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    mem_init = 1'b0;
    rst = 1'b0;
    idle(2);

    // Signed/unsigned byte loads from a known word.
    access(1'b1, 2'd2, 1'b0, 32'h10, 32'h81223344, 1'b0, d_at, ne, nr, se);
    chk32("sw_preload_word", mem[4], 32'h81223344);
    access(1'b0, 2'd0, 1'b1, 32'h10, 32'h0, 1'b0, d_at, ne, nr, se);
    chk32("lb_latency", 32'(d_at), 32'd2);
    chk32("lb_rdata", rdata, 32'hFFFFFF81);
    chk32("lb_en_cycles", 32'(ne), 32'd1);
    access(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 1'b0, d_at, ne, nr, se);
    chk32("lbu_rdata", rdata, 32'h00000044);

    // Byte store read-modify-write.
    access(1'b1, 2'd2, 1'b0, 32'h10, 32'h11223344, 1'b0, d_at, ne, nr, se);
    access(1'b1, 2'd0, 1'b0, 32'h11, 32'h000000AA, 1'b0, d_at, ne, nr, se);
    chk32("sb_latency", 32'(d_at), 32'd3);
    chk32("sb_en_cycles", 32'(ne), 32'd1);
    chk32("sb_rw_cycles", 32'(nr), 32'd1);
    chk32("sb_mem_word", mem[4], 32'h11AA3344);

    // Word store and read-back.
    access(1'b1, 2'd2, 1'b0, 32'h20, 32'hDEADBEEF, 1'b0, d_at, ne, nr, se);
    chk32("sw_latency", 32'(d_at), 32'd2);
    chk32("sw_en_cycles", 32'(ne), 32'd0);
    chk32("sw_rw_cycles", 32'(nr), 32'd1);
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b0, d_at, ne, nr, se);
    chk32("lw_rdata", rdata, 32'hDEADBEEF);

    // Rejected accesses.
    access(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 1'b0, d_at, ne, nr, se);
    chk32("lh_mis_latency", 32'(d_at), 32'd1);
    chk1 ("lh_mis_err", se, 1'b1);
    chk32("lh_mis_mem_cycles", 32'(ne + nr), 32'd0);
    access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 1'b0, d_at, ne, nr, se);
    chk1 ("lw_range_err", se, 1'b1);
    chk32("lw_range_rdata", rdata, 32'hDEADBEEF);
    access(1'b0, 2'd2, 1'b0, 32'hFC, 32'h0, 1'b0, d_at, ne, nr, se);
    chk1 ("lw_last_word_ok", se, 1'b0);

    // req held through a load, garbage fields while busy, store right after DONE.
    access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 1'b1, d_at, ne, nr, se);
    chk32("hold_en_cycles", 32'(ne), 32'd1);
    access(1'b1, 2'd0, 1'b0, 32'h21, 32'h00000055, 1'b0, d_at, ne, nr, se);
    chk32("hold_rdata_kept", rdata, 32'hDEADBEEF);
    chk32("hold_store_word", mem[8], 32'hDE55BEEF);
    idle(1);

    // Halfword store interrupted by reset while writing.
    @(posedge clk); #1;
    req = 1'b1; we = 1'b1; size = 2'd1; sign_ext = 1'b0; addr = 32'h12; wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    req = 1'b0;
    chk1("rst_case_rd_en", mem_en, 1'b1);
    @(posedge clk); #1;
    chk1("rst_case_wr_rw", mem_rw, 1'b1);
    rst = 1'b1;
    #1;
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    model_rdata = 32'd0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(3);
    chk32("rst_case_mem_word", mem[4], 32'h11AA3344);
    chk32("rst_case_mem_ref", mem[4], ref_mem[4]);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 300; i++) begin
      r_we_v = 1'($urandom);
      r_sx_v = 1'($urandom);
      r_sz_v = 2'($urandom_range(0, 3));
      r_wd_v = $urandom;
      if (i % 23 == 7) r_ad_v = 32'hFFFFFFFC | 32'($urandom_range(0, 3));
      else             r_ad_v = 32'($urandom_range(0, 32'h10F));
      r_hold = ($urandom_range(0, 7) == 0);
      access(r_we_v, r_sz_v, r_sx_v, r_ad_v, r_wd_v, r_hold, d_at, ne, nr, se);
      if ($urandom_range(0, 2) == 0) idle(1);
    end
    idle(2);
    for (int i = 0; i < 64; i++) chk32("final_mem", mem[i], ref_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
